// File: rtl/cnu_row_sequencer.sv
// cnu_row_sequencer: min-sum LDPC check-node row controller (reads, finder feed, sign parity, result handshake).
// Define CNU_OFFSET_EN for offset min-sum: captured magnitudes are saturating-reduced by OFFSET.
module cnu_row_sequencer #(
   parameter int DATA_WIDTH = 6,
   parameter int SIZE       = 8,
   parameter int NUM_ROWS   = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int ROW_WIDTH  = 2,
   parameter int OFFSET     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  fmin_clr,
   output logic                  fmin_en,
   output logic [DATA_WIDTH-1:0] fmin_index,
   output logic [DATA_WIDTH-1:0] fmin_value,
   input  logic [DATA_WIDTH-1:0] fmin_min1,
   input  logic [DATA_WIDTH-1:0] fmin_min2,
   input  logic [DATA_WIDTH-1:0] fmin_idx1,
   input  logic [DATA_WIDTH-1:0] fmin_idx2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_min1,
   output logic [DATA_WIDTH-1:0] out_min2,
   output logic [DATA_WIDTH-1:0] out_idx1,
   output logic [DATA_WIDTH-1:0] out_idx2,
   output logic                  out_sign,
   output logic [ROW_WIDTH-1:0]  out_row
);
   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_CAPTURE, S_OUT, S_DONE} state_t;

   state_t                r_state;
   logic [ROW_WIDTH-1:0]  r_row;
   logic [CW-1:0]         r_col;
   logic                  r_sign;
   logic [DATA_WIDTH-1:0] w_min1;
   logic [DATA_WIDTH-1:0] w_min2;

`ifdef CNU_OFFSET_EN
   localparam logic [DATA_WIDTH-1:0] OFF = DATA_WIDTH'(OFFSET);
   assign w_min1 = (fmin_min1 > OFF) ? fmin_min1 - OFF : '0;
   assign w_min2 = (fmin_min2 > OFF) ? fmin_min2 - OFF : '0;
`else
   assign w_min1 = fmin_min1;
   assign w_min2 = fmin_min2;
`endif

   assign fmin_value = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_sign     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         fmin_clr   <= 1'b0;
         fmin_en    <= 1'b0;
         fmin_index <= '0;
         out_valid  <= 1'b0;
         out_min1   <= '0;
         out_min2   <= '0;
         out_idx1   <= '0;
         out_idx2   <= '0;
         out_sign   <= 1'b0;
         out_row    <= '0;
      end else begin
         // finder sees each message one cycle after its read, matching RAM latency
         fmin_en    <= mem_rd_en;
         fmin_index <= DATA_WIDTH'(r_col);
         fmin_clr   <= 1'b0;
         done       <= 1'b0;
         if (fmin_en) r_sign <= r_sign ^ mem_rdata[DATA_WIDTH-1];
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row    <= '0;
                  fmin_clr <= 1'b1;
                  busy     <= 1'b1;
                  r_state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_col     <= '0;
               r_sign    <= 1'b0;
               mem_rd_en <= 1'b1;
               mem_addr  <= ADDR_WIDTH'(int'(r_row) * SIZE);
               r_state   <= S_READ;
            end
            S_READ: begin
               if (r_col == CW'(SIZE - 1)) begin
                  mem_rd_en <= 1'b0;
                  r_state   <= S_DRAIN;
               end else begin
                  r_col    <= r_col + CW'(1);
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: r_state <= S_CAPTURE;
            S_CAPTURE: begin
               out_min1  <= w_min1;
               out_min2  <= w_min2;
               out_idx1  <= fmin_idx1;
               out_idx2  <= fmin_idx2;
               out_sign  <= r_sign;
               out_row   <= r_row;
               out_valid <= 1'b1;
               r_state   <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (r_row == ROW_WIDTH'(NUM_ROWS - 1)) begin
                     done    <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_row    <= r_row + ROW_WIDTH'(1);
                     fmin_clr <= 1'b1;
                     r_state  <= S_CLEAR;
                  end
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnu_row_sequencer.sv
// tb_cnu_row_sequencer: bench with message RAM, min/second-min finder stand-in and a row-result model.
module tb_cnu_row_sequencer;
   localparam int DW = 6, SZ = 8, NR = 4, AW = 5, RW = 2;
`ifdef CNU_OFFSET_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic          busy, done, mem_rd_en, fmin_clr, fmin_en, out_valid, out_sign;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata, fmin_index, fmin_value;
   logic [DW-1:0] f_min1, f_min2, f_idx1, f_idx2, f_mag;
   logic [DW-1:0] out_min1, out_min2, out_idx1, out_idx2;
   logic [RW-1:0] out_row;

   logic signed [DW-1:0] mem [NR*SZ];
   int rows [NR*SZ] = '{ 5, -3, 7, -1, 2, -6, 4, 3,
                         4, 4, 4, 4, 4, 4, 4, 4,
                        -8, -8, 9, -2, 10, -11, 12, 2,
                        -1, -1, -1, -1, 31, -32, 0, 5};

   int checks = 0, failures = 0;
   int exp_row = 0, exp_addr = 0;
   int fv, dc, dn, clr;
   int c0 [6], c1 [6];

   cnu_row_sequencer #(.DATA_WIDTH(DW), .SIZE(SZ), .NUM_ROWS(NR), .ADDR_WIDTH(AW),
                       .ROW_WIDTH(RW), .OFFSET(1)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .fmin_clr(fmin_clr), .fmin_en(fmin_en), .fmin_index(fmin_index), .fmin_value(fmin_value),
      .fmin_min1(f_min1), .fmin_min2(f_min2), .fmin_idx1(f_idx1), .fmin_idx2(f_idx2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_min1(out_min1), .out_min2(out_min2), .out_idx1(out_idx1), .out_idx2(out_idx2),
      .out_sign(out_sign), .out_row(out_row));

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   // finder stand-in: ties move the later index into first place
   assign f_mag = fmin_value[DW-1] ? -fmin_value : fmin_value;
   always @(posedge clk) begin
      if (rst || fmin_clr) begin
         f_min1 <= '1; f_min2 <= '1; f_idx1 <= '0; f_idx2 <= '0;
      end else if (fmin_en) begin
         if (f_mag <= f_min1) begin
            f_min2 <= f_min1; f_idx2 <= f_idx1; f_min1 <= f_mag; f_idx1 <= fmin_index;
         end else if (f_mag <= f_min2) begin
            f_min2 <= f_mag; f_idx2 <= fmin_index;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic void model(input int r, output int m1, output int i1,
                                 output int m2, output int i2, output int s);
      int mag [SZ];
      int v;
      m1 = 1000; m2 = 1000; i1 = 0; i2 = 0; s = 0;
      for (int j = 0; j < SZ; j++) begin
         v = int'(mem[r*SZ+j]);
         mag[j] = (v < 0) ? -v : v;
         if (v < 0) s ^= 1;
         if (mag[j] < m1) m1 = mag[j];
      end
      for (int j = 0; j < SZ; j++) if (mag[j] == m1) i1 = j;
      for (int j = 0; j < SZ; j++) if (j != i1 && mag[j] < m2) m2 = mag[j];
      for (int j = 0; j < SZ; j++) if (j != i1 && mag[j] == m2) i2 = j;
      m1 = (m1 > OFF) ? m1 - OFF : 0;
      m2 = (m2 > OFF) ? m2 - OFF : 0;
   endfunction

   initial begin : compare
      int m1, i1, m2, i2, s, p_addr;
      logic p_rd, p_stall;
      p_rd = 1'b0; p_stall = 1'b0; p_addr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_row = 0; exp_addr = 0; p_rd = 1'b0; p_stall = 1'b0;
         end else begin
            if (start && !busy) begin exp_row = 0; exp_addr = 0; end
            chk("fmin_en", fmin_en, p_rd);
            if (p_rd) chk("fmin_index", fmin_index, p_addr % SZ);
            if (mem_rd_en) begin
               chk("mem_addr", mem_addr, exp_addr);
               exp_addr++;
            end
            if (p_stall) chk("held_valid", out_valid, 1);
            if (out_valid) begin
               model(exp_row, m1, i1, m2, i2, s);
               chk("read_in_out", mem_rd_en, 0);
               chk("out_row", out_row, exp_row);
               chk("out_min1", out_min1, m1);
               chk("out_idx1", out_idx1, i1);
               chk("out_min2", out_min2, m2);
               chk("out_idx2", out_idx2, i2);
               chk("out_sign", out_sign, s);
               if (out_ready) exp_row++;
            end
            if (!busy) chk("idle_quiet", {mem_rd_en, out_valid, fmin_en}, 0);
            p_rd = mem_rd_en; p_addr = mem_addr; p_stall = out_valid && !out_ready;
         end
      end
   end

   task automatic run_pass(input int stall, input int rst_cyc, input int st_cyc);
      bit fin;
      fv = -1; dc = -1; dn = 0; clr = -1; fin = 0;
      @(posedge clk); #1; start = 1'b1; out_ready = (stall == 0);
      @(posedge clk); #1; start = 1'b0;
      for (int n = 1; n <= 120 && !fin; n++) begin
         out_ready = !(stall > 0 && n >= 12 && n < 12 + stall);
         rst = (n == rst_cyc);
         start = (n == st_cyc);
         @(negedge clk);
         if (out_valid && fv < 0) begin
            fv = n;
            c0 = '{int'(out_min1), int'(out_idx1), int'(out_min2), int'(out_idx2), int'(out_sign), int'(out_row)};
         end
         if (n == 24 && stall == 0)
            c1 = '{int'(out_min1), int'(out_idx1), int'(out_min2), int'(out_idx2), int'(out_sign), int'(out_row)};
         if (n == 13 + stall) clr = fmin_clr;
         if (done) begin dn++; dc = n; end
         if (rst_cyc > 0 && n == rst_cyc + 1) begin
            chk("post_reset", {busy, mem_rd_en, fmin_en, out_valid}, 0);
            fin = 1;
         end
         if (dc > 0 && n == dc + 1) begin
            chk("busy_after_done", {busy, done}, 0);
            fin = 1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; rst = 1'b0;
      if (!fin) chk("pass_timeout", 0, 1);
   endtask

   initial begin : main
      int e0 [6], e1 [6];
      e0 = '{1 - OFF, 3, 2 - OFF, 4, 1, 0};
      e1 = '{4 - OFF, 7, 4 - OFF, 6, 0, 1};
      for (int i = 0; i < NR*SZ; i++) mem[i] = rows[i][DW-1:0];
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {busy, done, mem_rd_en, fmin_clr, fmin_en, out_valid}, 0);
      chk("rst_addr", {mem_addr, fmin_index}, 0);
      chk("rst_out", {out_min1, out_min2, out_idx1, out_idx2, out_sign, out_row}, 0);
      @(posedge clk); #1; rst = 1'b0;

      run_pass(0, 0, 0);
      chk("p1_first_valid", fv, 12);
      chk("p1_done_cycle", dc, 49);
      chk("p1_done_pulses", dn, 1);
      chk("p1_results", exp_row, 4);
      chk("p1_reads", exp_addr, 32);
      for (int k = 0; k < 6; k++) chk($sformatf("p1_row0_f%0d", k), c0[k], e0[k]);
      for (int k = 0; k < 6; k++) chk($sformatf("p1_row1_f%0d", k), c1[k], e1[k]);

      run_pass(5, 0, 0);
      chk("p2_first_valid", fv, 12);
      chk("p2_clear_after_accept", clr, 1);
      chk("p2_done_cycle", dc, 54);
      chk("p2_done_pulses", dn, 1);
      chk("p2_results", exp_row, 4);

      run_pass(0, 4, 0);
      chk("p3_no_valid", fv, -1);
      chk("p3_no_done", dn, 0);

      run_pass(0, 0, 20);
      chk("p4_first_valid", fv, 12);
      chk("p4_done_cycle", dc, 49);
      chk("p4_done_pulses", dn, 1);
      chk("p4_results", exp_row, 4);
      for (int k = 0; k < 6; k++) chk($sformatf("p4_row0_f%0d", k), c0[k], e0[k]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cnu_row_sequencer.md
Name: cnu_row_sequencer

Overview:
- Check-node row controller for the min-sum LDPC decoder.
- For each parity-check row, it reads the row's SIZE variable-to-check messages from the message memory, streams them into the external min/second-min finder, and accumulates the sign parity.
- It then captures the finder results and presents them with a valid/ready handshake. After NUM_ROWS rows it pulses done.
- It sits between the message RAM, the finder instance and the check-to-variable update stage.

Parameters:
- DATA_WIDTH, 6: message width (signed two's complement); also the finder index/magnitude width.
- SIZE, 8: row degree; messages per row.
- NUM_ROWS, 4: rows processed per start.
- ADDR_WIDTH, 5: memory address width; must be >= clog2(NUM_ROWS*SIZE).
- ROW_WIDTH, 2: row counter width; must be >= clog2(NUM_ROWS).
- OFFSET, 1: offset subtracted when CNU_OFFSET_EN is defined.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a NUM_ROWS pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row's result is accepted.
- mem_rd_en  out  1  message memory read strobe.
- mem_addr  out  ADDR_WIDTH  read address = row*SIZE + col.
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- fmin_clr  out  1  drives the finder's rst; high for one cycle per row.
- fmin_en  out  1  finder enable.
- fmin_index  out  DATA_WIDTH  column index, zero-extended.
- fmin_value  out  DATA_WIDTH  message value (mem_rdata passthrough).
- fmin_min1, fmin_min2, fmin_idx1, fmin_idx2  in  DATA_WIDTH each  finder outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_min1, out_min2, out_idx1, out_idx2  out  DATA_WIDTH each  captured row result.
- out_sign  out  1  XOR of the sign bits of the row's SIZE messages.
- out_row  out  ROW_WIDTH  row number of the presented result.

Behaviour:
- Reset (synchronous, any state, including mid-row): state <= IDLE. busy, done, mem_rd_en, fmin_clr, fmin_en, out_valid = 0. mem_addr, fmin_index, all out_* and out_row = 0. Row/col counters and sign accumulator = 0.
- fmin_clr is 0 during reset; the integrator ORs rst into the finder's reset.
- IDLE: on start=1, row <= 0 and go to CLEAR. start is ignored in all other states.
- CLEAR, 1 cycle: fmin_clr=1; col <= 0; sign <= 0; go to READ.
- READ, SIZE cycles: mem_rd_en=1, mem_addr=row*SIZE+col, col increments each cycle. Leave to DRAIN after col==SIZE-1.
- Read pipeline: rd_en and col are delayed 1 cycle into fmin_en and fmin_index. fmin_value = mem_rdata.
- Sign accumulation: sign ^= mem_rdata[DATA_WIDTH-1] on every cycle where the delayed rd_en is high.
- DRAIN, 1 cycle: last element presented (fmin_en=1); no read.
- CAPTURE, 1 cycle: finder outputs are now final. At the end of the cycle, latch fmin_* into out_min1/out_min2/out_idx1/out_idx2, sign into out_sign, row into out_row. Go to OUT.
- OUT: out_valid=1; all out_* held stable until out_valid && out_ready.
  - On accept with row==NUM_ROWS-1: go to DONE.
  - On accept otherwise: row++ and go to CLEAR.
  - out_valid drops the cycle after accept.
- DONE, 1 cycle: done=1; then IDLE.
- Latency: call the cycle start is sampled cycle 0. CLEAR is cycle 1, READ is cycles 2..SIZE+1, DRAIN SIZE+2, CAPTURE SIZE+3, and out_valid rises in cycle SIZE+4.
- Throughput with out_ready held high: SIZE+4 cycles per row. done occurs NUM_ROWS*(SIZE+4)+1 cycles after start.
- No memory reads are issued while waiting in OUT.
- Out-of-range addresses are impossible given the parameter constraints.

Optional Feature:
- CNU_OFFSET_EN defined: at CAPTURE, out_min1 = max(fmin_min1 - OFFSET, 0) and out_min2 = max(fmin_min2 - OFFSET, 0), i.e. unsigned saturating subtraction (offset min-sum). Index, sign and timing are unchanged.
- Undefined: magnitudes pass through unmodified.

Test Plan:
- Single row, NUM_ROWS=1, row0 = {5,-3,7,-1,2,-6,4,3} -> out_valid at cycle 12; out_min1=1, out_idx1=3, out_min2=2, out_idx2=4, out_sign=1, out_row=0; done one cycle after accept.
- Tie row, all values +4 -> out_min1=4, out_idx1=7, out_min2=4, out_idx2=6, out_sign=0.
- Back-pressure: out_ready low for 5 cycles in OUT -> all out_* stable, mem_rd_en=0 throughout, out_row unchanged; accept on the 6th cycle -> next CLEAR follows.
- Full pass, NUM_ROWS=4, out_ready=1 -> mem_addr sequence 0..31 in order, four results with out_row 0..3, a single done pulse at cycle 49, busy low afterwards.
- rst asserted in the 3rd READ cycle -> next cycle busy=0, mem_rd_en=0, fmin_en=0, out_valid=0. A new start then yields row 0 results identical to a clean run.
- start pulsed while busy is ignored (no restart, same results). With CNU_OFFSET_EN and OFFSET=1, the first-row test gives out_min1=0, out_min2=1.
